// File: rtl/pwm_capture_pkg.sv
// Shared definitions for PWM capture: FSM state encoding and counter range helper.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

  // Largest value a w-bit period/high-time counter can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bus: the raw PWM input and the measurement results.
// valid is a one-cycle strobe with no back-pressure; a consumer samples period/high_time while valid is high.
interface pwm_capture_if #(
  parameter int W = 8
);
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         no_signal;
  logic         level;

  modport master (
    input  pwm_in,
    output period, high_time, valid, no_signal, level
  );

  modport slave (
    output pwm_in,
    input  period, high_time, valid, no_signal, level
  );
endinterface

// File: rtl/pwm_capture_sync_edge_detect.sv
// Synchronizes an asynchronous input and flags its rising/falling edges.
module pwm_capture_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic cclk,
  input  logic rstb,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~prev_q;
  assign fall_o = ~s_o & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in cclk cycles and
// flags a stuck input when no edge arrives within the counter range.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               cclk,
  input  logic               rstb,
  pwm_capture_if.master      bus,
  output cap_state_e         state_o
);

  localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));

  logic s, rise, fall;

  pwm_capture_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .cclk    (cclk),
    .rstb    (rstb),
    .async_i (bus.pwm_in),
    .s_o     (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  cap_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         valid_q, valid_d;
  logic         nosig_q, nosig_d;
  logic         level_q;
  logic         at_max;

  assign at_max = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    nosig_d  = nosig_q;

    if (rise) begin
      cnt_d = W'(1);
    end else if (state_q != ST_IDLE && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end

    // A timeout wins over a coincident edge so a wrapped measurement is never published.
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          nosig_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (at_max) begin
          state_d = ST_IDLE;
          nosig_d = 1'b1;
        end else if (fall) begin
          state_d = ST_LOW;
          hi_d    = cnt_q;
        end
      end
      ST_LOW: begin
        if (at_max) begin
          state_d = ST_IDLE;
          nosig_d = 1'b1;
        end else if (rise) begin
          state_d  = ST_HIGH;
          period_d = cnt_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      nosig_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      nosig_q  <= nosig_d;
      level_q  <= s;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.no_signal = nosig_q;
  assign bus.level     = level_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture with an edge-timestamp reference model and scoreboard.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int MAXC = (1 << W) - 1;

  // clock / reset
  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  cap_state_e state_dbg;

  always #5 cclk = ~cclk;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(.W(W), .SYNC_STAGES(SS)) dut (
    .cclk    (cclk),
    .rstb    (rstb),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] e_item;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_period = -1;
  int last_high   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: works on timestamps of synchronized edges.
  logic [SS-1:0] m_hist = '0;
  logic m_prev = 1'b0, m_s, m_r, m_f;
  int   m_mode = 0;          // 0 waiting for first rise, 1 high phase, 2 low phase
  int   m_last_rise = 0, m_hi = 0, m_age;
  logic m_ns = 1'b0, m_level = 1'b0, m_valid = 1'b0;
  int   m_period = 0, m_high = 0;

  always @(posedge cclk) begin
    cyc++;
    if (!rstb) begin
      m_hist = '0; m_prev = 1'b0; m_mode = 0; m_ns = 1'b0; m_level = 1'b0;
      m_valid = 1'b0; m_period = 0; m_high = 0; m_hi = 0;
    end else begin
      m_s = m_hist[SS-1];
      m_r = m_s & ~m_prev;
      m_f = ~m_s & m_prev;
      m_age = cyc - m_last_rise;
      m_valid = 1'b0;
      case (m_mode)
        0: if (m_r) begin m_mode = 1; m_last_rise = cyc; m_ns = 1'b0; end
        1: if (m_age >= MAXC) begin m_mode = 0; m_ns = 1'b1; end
           else if (m_f) begin m_hi = m_age; m_mode = 2; end
        2: if (m_age >= MAXC) begin m_mode = 0; m_ns = 1'b1; end
           else if (m_r) begin
             m_period = m_age; m_high = m_hi; m_valid = 1'b1;
             exp_q.push_back({W'(m_age), W'(m_hi)});
             m_last_rise = cyc; m_mode = 1;
           end
        default: m_mode = 0;
      endcase
      m_level = m_s;
      m_prev  = m_s;
      m_hist  = {m_hist[SS-2:0], bus.pwm_in};
    end
  end

  // monitor
  always @(negedge cclk) begin
    chk("valid", bus.valid, m_valid);
    chk("no_signal", bus.no_signal, m_ns);
    chk("level", bus.level, m_level);
    chk("period_hold", bus.period, m_period);
    chk("high_hold", bus.high_time, m_high);
    if (bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        e_item = exp_q.pop_front();
        chk("sb_period", bus.period, e_item[2*W-1:W]);
        chk("sb_high", bus.high_time, e_item[W-1:0]);
        last_period = bus.period;
        last_high   = bus.high_time;
      end
    end
  end

  // drivers (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge cclk);
  endtask

  task automatic hold(input logic v, input int n);
    bus.pwm_in = v;
    tick(n);
  endtask

  task automatic wave(input int per, input int hi, input int nper);
    for (int p = 0; p < nper; p++) begin
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  initial begin
    int per, hi;
    bus.pwm_in = 1'b0;
    rstb = 1'b0;
    tick(3);
    chk("rst_period", bus.period, 0);
    chk("rst_high", bus.high_time, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_no_signal", bus.no_signal, 0);
    chk("rst_level", bus.level, 0);
    rstb = 1'b1;
    tick(2);

    // square wave 10/3
    wave(10, 3, 6);
    chk("t1_period", last_period, 10);
    chk("t1_high", last_high, 3);

    // stuck low
    hold(1'b0, 300);
    chk("t3_no_signal", bus.no_signal, 1);
    chk("t3_level", bus.level, 0);
    chk("t3_period_kept", bus.period, 10);
    chk("t3_high_kept", bus.high_time, 3);
    wave(10, 3, 3);
    chk("t3_cleared", bus.no_signal, 0);

    // minimum pulse
    wave(4, 1, 5);
    chk("t2_min_period", last_period, 4);
    chk("t2_min_high", last_high, 1);

    // stuck high
    hold(1'b1, 300);
    chk("t4_no_signal", bus.no_signal, 1);
    chk("t4_level", bus.level, 1);
    chk("t4_period_kept", bus.period, 4);
    chk("t4_high_kept", bus.high_time, 1);

    // longest measurable period
    wave(254, 253, 4);
    chk("t2_max_period", last_period, 254);
    chk("t2_max_high", last_high, 253);

    // reset mid-high
    wave(10, 3, 3);
    hold(1'b1, 4);
    rstb = 1'b0;
    tick(1);
    chk("t5_period", bus.period, 0);
    chk("t5_high", bus.high_time, 0);
    chk("t5_valid", bus.valid, 0);
    chk("t5_no_signal", bus.no_signal, 0);
    chk("t5_level", bus.level, 0);
    rstb = 1'b1;
    hold(1'b1, 1);
    wave(10, 3, 4);

    // period change on the fly
    wave(10, 3, 4);
    wave(20, 15, 5);
    chk("t6_period", last_period, 20);
    chk("t6_high", last_high, 15);

    // random segments
    for (int k = 0; k < 12; k++) begin
      per = $urandom_range(254, 2);
      hi  = $urandom_range(per - 1, 1);
      wave(per, hi, $urandom_range(4, 2));
      if ($urandom_range(3, 0) == 0)
        hold(1'($urandom_range(1, 0)), $urandom_range(300, 20));
    end

    hold(1'b0, 8);
    chk("drain_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
